// File: rtl/keypad_scan_ctrl_if.sv
// Keypad scan controller signal bundle: column inputs in, row drive and
// two-digit display outputs out.
interface keypad_scan_ctrl_if;
   logic [3:0] col_sync;
   logic [3:0] r_sel;
   logic [3:0] key_code;
   logic       key_valid;
   logic [3:0] left;
   logic [3:0] right;

   modport master (
      input  col_sync,
      output r_sel, key_code, key_valid, left, right
   );

   modport slave (
      output col_sync,
      input  r_sel, key_code, key_valid, left, right
   );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 hex keypad scanner with press/release debounce and a two-digit
// shift register for the seven-segment display.
module keypad_scan_ctrl #(
   parameter int SCAN_DIV  = 4,
   parameter int DB_CYCLES = 8
) (
   input logic                clk,
   input logic                reset,
   keypad_scan_ctrl_if.master kp
);

   localparam int CNT_MAX = (SCAN_DIV > DB_CYCLES) ? SCAN_DIV : DB_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);

   localparam logic [1:0] ST_SCAN       = 2'd0;
   localparam logic [1:0] ST_DB_PRESS   = 2'd1;
   localparam logic [1:0] ST_HELD       = 2'd2;
   localparam logic [1:0] ST_DB_RELEASE = 2'd3;

   logic [1:0]       state, state_nxt;
   logic [1:0]       row, row_nxt;
   logic [3:0]       col, col_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             accept;
   logic             one_hot;
   logic             latched_hit;
   logic [3:0]       new_code;

   function automatic logic [3:0] key_map(input logic [1:0] r, input logic [3:0] c);
      logic [1:0] ci;
      ci = 2'd0;
      case (c)
         4'b0010: ci = 2'd1;
         4'b0100: ci = 2'd2;
         4'b1000: ci = 2'd3;
         default: ci = 2'd0;
      endcase
      case ({r, ci})
         4'h0: key_map = 4'h1;
         4'h1: key_map = 4'h2;
         4'h2: key_map = 4'h3;
         4'h3: key_map = 4'hA;
         4'h4: key_map = 4'h4;
         4'h5: key_map = 4'h5;
         4'h6: key_map = 4'h6;
         4'h7: key_map = 4'hB;
         4'h8: key_map = 4'h7;
         4'h9: key_map = 4'h8;
         4'hA: key_map = 4'h9;
         4'hB: key_map = 4'hC;
         4'hC: key_map = 4'hF;
         4'hD: key_map = 4'h0;
         4'hE: key_map = 4'hE;
         default: key_map = 4'hD;
      endcase
   endfunction

   assign one_hot     = (kp.col_sync != 4'b0) &&
                        ((kp.col_sync & (kp.col_sync - 4'd1)) == 4'b0);
   assign latched_hit = (kp.col_sync & col) != 4'b0;
   assign new_code    = key_map(row, col);

   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      state_nxt = state;
      row_nxt   = row;
      col_nxt   = col;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      case (state)
         ST_SCAN: begin
            if (cnt < SCAN_LAST) begin
               cnt_nxt = cnt + 1'b1;
            end else if (one_hot) begin
               col_nxt   = kp.col_sync;
               cnt_nxt   = '0;
               state_nxt = ST_DB_PRESS;
            end else begin
               row_nxt = row + 2'd1;
               cnt_nxt = '0;
            end
         end
         ST_DB_PRESS: begin
            if (kp.col_sync != col) begin
               cnt_nxt   = '0;
               state_nxt = ST_SCAN;
            end else if (cnt == DB_LAST) begin
               cnt_nxt   = '0;
               state_nxt = ST_HELD;
               accept    = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         ST_HELD: begin
            // Other columns on this row are deliberately ignored while held.
            if (!latched_hit) begin
               cnt_nxt   = '0;
               state_nxt = ST_DB_RELEASE;
            end
         end
         default: begin
            if (latched_hit) begin
               cnt_nxt   = '0;
               state_nxt = ST_HELD;
            end else if (cnt == DB_LAST) begin
               cnt_nxt   = '0;
               row_nxt   = row + 2'd1;
               state_nxt = ST_SCAN;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= ST_SCAN;
         row          <= 2'd0;
         col          <= 4'b0;
         cnt          <= '0;
         kp.r_sel     <= 4'b1110;
         kp.key_code  <= 4'h0;
         kp.key_valid <= 1'b0;
         kp.left      <= 4'h0;
         kp.right     <= 4'h0;
      end else begin
         state        <= state_nxt;
         row          <= row_nxt;
         col          <= col_nxt;
         cnt          <= cnt_nxt;
         kp.r_sel     <= ~(4'b0001 << row_nxt);
         kp.key_valid <= accept;
         if (accept) begin
            kp.key_code <= new_code;
            kp.right    <= new_code;
            kp.left     <= kp.right;
         end
      end
   end

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Scan controller for the 4x4 hex keypad that feeds the dual seven-segment display. It drives the active-low row selects, samples the synchronized column inputs, and debounces both press and release with a dwell/debounce counter. Each debounced press produces exactly one `key_valid` pulse and shifts the two-digit display register: `left` takes the old `right`, and `right` takes the new key. It sits between the column synchronizer and the display multiplexer.

## Interface
- `SCAN_DIV`, default 4: clock cycles each row is driven before its columns are sampled. Must be ≥2.
- `DB_CYCLES`, default 8: consecutive stable cycles required to accept a press or a release. Must be ≥1.
- `clk`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-low; clock `clk`.
- `col_sync`  in  4  synchronized column inputs, active-high. Bit 0 is column 0.
- `r_sel`  out  4  row drive, active-low, one-cold. Row 0 is `4'b1110`.
- `key_code`  out  4  hex value of the last accepted key.
- `key_valid`  out  1  one-cycle pulse per accepted press.
- `left`  out  4  left display digit.
- `right`  out  4  right display digit.

## Operation
- Registers:
  - `state`: SCAN, DB_PRESS, HELD, DB_RELEASE.
  - 2-bit `row`.
  - 4-bit latched `col`.
  - Counter `cnt` of width `$clog2(max(SCAN_DIV,DB_CYCLES))`.
- All outputs are registered. `r_sel` is decoded from `row` only: `~(4'b0001 << row)`.
- Key map, indexed by row then column 0..3:
  - Row 0: 1, 2, 3, A.
  - Row 1: 4, 5, 6, B.
  - Row 2: 7, 8, 9, C.
  - Row 3: F, 0, E, D.
- **SCAN**:
  - While `cnt < SCAN_DIV-1`: `cnt++`.
  - At `cnt == SCAN_DIV-1`, if `col_sync` is one-hot: latch `col = col_sync`, clear `cnt`, go to DB_PRESS. `row` is held.
  - At `cnt == SCAN_DIV-1` otherwise (zero or multiple bits set): `row++` (wraps 3→0) and clear `cnt`.
- **DB_PRESS**:
  - If `col_sync != col`: clear `cnt`, return to SCAN on the same row.
  - Else if `cnt == DB_CYCLES-1`: go to HELD and accept the key (see below), clear `cnt`.
  - Else `cnt++`.
- **Accept** (single edge): `key_code <= map[row][col]`, `right <= map[row][col]`, `left <= right`, `key_valid <= 1`.
- **HELD**:
  - `row` is held. Only `col_sync & col` is examined; other columns are ignored.
  - If the latched bit drops: clear `cnt`, go to DB_RELEASE.
  - No repeat pulses while the key is held.
- **DB_RELEASE**:
  - If the latched bit reasserts: go to HELD, clear `cnt`. No new pulse.
  - Else if `cnt == DB_CYCLES-1`: go to SCAN, `row++`, clear `cnt`.
  - Else `cnt++`.
- `key_valid` is 0 in every cycle except the one after acceptance.
- Keys on undriven rows are invisible by construction. A second key pressed while HELD is ignored until the first is released and scanning resumes.
- Reset, when `reset == 0` at a posedge, regardless of state:
  - `state = SCAN`, `row = 0`, `r_sel = 4'b1110`, `cnt = 0`.
  - `col = 0`, `key_code = 0`, `key_valid = 0`, `left = 0`, `right = 0`.
  - An in-flight press or hold is discarded.

## Timing
- A row is sampled on its `SCAN_DIV`-th driven cycle. With no keys pressed, the full scan period is `4*SCAN_DIV` cycles.
- Press latency: the sample edge enters DB_PRESS. After `DB_CYCLES` matching cycles, `key_valid`, `key_code`, `left` and `right` update on the same edge, in the first HELD cycle.
- Release latency: after the latched bit drops, `DB_CYCLES` low cycles pass, then one more edge before `r_sel` advances to the next row.
- A bounce of fewer than `DB_CYCLES` cycles during DB_PRESS aborts the press: no pulse, rescan of the same row after a full dwell.
- A bounce of fewer than `DB_CYCLES` cycles during DB_RELEASE causes no second pulse.
- `r_sel` never changes outside SCAN's dwell-end edge, DB_RELEASE completion, or reset.

## Test plan
All scenarios use `SCAN_DIV=4`, `DB_CYCLES=8`.
- **Reset, idle:** hold `reset=0` for 2 cycles, then release with `col_sync=0` → all outputs 0; `r_sel` sequences 1110, 1101, 1011, 0111, 1110, changing every 4 cycles.
- **Single key:** press '5' (row 1, `col_sync=4'b0010` whenever `r_sel=1101`), held 50 cycles →
  - exactly one `key_valid`, `key_code=5`, `right=5`, `left=0`;
  - `r_sel` stays 1101 until 8 cycles after release, then 1011.
- **Bounce on press:** row 0, col 0 asserted for 5 cycles, low for 1, then stable →
  - the first attempt aborts;
  - one `key_valid` with `key_code=1`;
  - a 3-cycle release glitch while held produces no second pulse.
- **Sequence:** press and release '1', then 'D' (row 3, `col_sync=4'b1000`) → `left=1`, `right=D`, two pulses total.
- **Multi-column:** `col_sync=4'b0011` on row 0 → no pulse; `r_sel` advances to 1101 after 4 cycles.
- **Reset mid-hold:** assert reset while '9' is HELD → next cycle all outputs 0 and `r_sel=1110`; releasing '9' afterwards produces no pulse.
